// File: rtl/cdac_ser_rx_pkg.sv
// Shared types and default constants for the CDAC serial-load receiver.
// The optional frame timeout is enabled by defining CDAC_RX_TIMEOUT_EN.
package cdac_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK,
    WAIT_HI
  } rx_state_t;

  localparam int DEF_FRAME_BITS = 16;
  localparam int DEF_CODE_W     = 12;
  localparam int DEF_TO_CYCLES  = 255;

endpackage

// File: rtl/cdac_ser_rx_if.sv
// Serial-load lines plus the recovered parallel word and status.
// master = loader/monitor side, slave = receiver.
interface cdac_ser_rx_if
  import cdac_rx_pkg::*;
#(
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int CODE_W     = DEF_CODE_W
);

  logic                         SCLK;
  logic                         SDATA;
  logic                         DAC_ENB;
  logic [FRAME_BITS-CODE_W-1:0] CTRL;
  logic [CODE_W-1:0]            CODE;
  logic                         DATA_VLD;
  logic                         FRAME_ERR;
  logic                         BUSY;
  logic [7:0]                   FRAME_CNT;

  modport master (
    output SCLK, SDATA, DAC_ENB,
    input  CTRL, CODE, DATA_VLD, FRAME_ERR, BUSY, FRAME_CNT
  );

  modport slave (
    input  SCLK, SDATA, DAC_ENB,
    output CTRL, CODE, DATA_VLD, FRAME_ERR, BUSY, FRAME_CNT
  );

endinterface

// File: rtl/cdac_ser_rx_sync_edge.sv
// Two-flop synchronizer with a history flop for rise/fall detection.
// Edges are suppressed until the pipeline has refilled with real samples after reset.
module sync_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic       r_s1;
  logic       r_s2;
  logic       r_hist;
  logic [2:0] r_fill;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1   <= RST_VAL;
      r_s2   <= RST_VAL;
      r_hist <= RST_VAL;
      r_fill <= '0;
    end else begin
      r_s1   <= i_d;
      r_s2   <= r_s1;
      r_hist <= r_s2;
      r_fill <= {r_fill[1:0], 1'b1};
    end
  end

  // A level held across reset must not look like an edge once the preset values drain out.
  assign o_q    = r_s2;
  assign o_rise = r_fill[2] &  r_s2 & ~r_hist;
  assign o_fall = r_fill[2] & ~r_s2 &  r_hist;

endmodule

// File: rtl/cdac_ser_rx.sv
// CDAC serial-load receiver: oversamples SCLK/SDATA/DAC_ENB on CLK40 and checks frame length.
// Define CDAC_RX_TIMEOUT_EN to abort frames whose SCLK stalls while selected.
module cdac_ser_rx
  import cdac_rx_pkg::*;
#(
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int CODE_W     = DEF_CODE_W
`ifdef CDAC_RX_TIMEOUT_EN
  ,
  parameter int TO_CYCLES  = DEF_TO_CYCLES
`endif
) (
  input logic           CLK40,
  input logic           RST_B,
  cdac_ser_rx_if.slave  bus
);

  localparam int         CTRL_W = FRAME_BITS - CODE_W;
  localparam logic [4:0] C_FULL = 5'(FRAME_BITS);

  logic [2:0] w_pin;
  logic [2:0] w_lvl;
  logic [2:0] w_rise;
  logic [2:0] w_fall;
  logic       w_unused;

  assign w_pin = {bus.DAC_ENB, bus.SDATA, bus.SCLK};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      sync_edge #(.RST_VAL(1'b1)) u_sync (
        .i_clk   (CLK40),
        .i_rst_n (RST_B),
        .i_d     (w_pin[gi]),
        .o_q     (w_lvl[gi]),
        .o_rise  (w_rise[gi]),
        .o_fall  (w_fall[gi])
      );
    end
  endgenerate

  logic w_sclk_rise;
  logic w_sdata;
  logic w_enb_fall;
  logic w_enb_rise;

  assign w_sclk_rise = w_rise[0];
  assign w_sdata     = w_lvl[1];
  assign w_enb_fall  = w_fall[2];
  assign w_enb_rise  = w_rise[2];
  assign w_unused    = ^{w_lvl[0], w_lvl[2], w_fall[1:0], w_rise[1]};

  rx_state_t             r_state;
  logic [FRAME_BITS-1:0] r_shreg;
  logic [4:0]            r_bitcnt;
  logic [CTRL_W-1:0]     r_ctrl;
  logic [CODE_W-1:0]     r_code;
  logic                  r_vld;
  logic                  r_err;
  logic                  r_busy;
  logic [7:0]            r_cnt;
`ifdef CDAC_RX_TIMEOUT_EN
  localparam logic [7:0] C_TO = 8'(TO_CYCLES);
  logic [7:0]            r_idle;
`endif

  always_ff @(posedge CLK40 or negedge RST_B) begin
    if (!RST_B) begin
      r_state  <= IDLE;
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_ctrl   <= '0;
      r_code   <= '0;
      r_vld    <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_cnt    <= '0;
`ifdef CDAC_RX_TIMEOUT_EN
      r_idle   <= '0;
`endif
    end else begin
      r_vld <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_enb_fall) begin
            r_state  <= SHIFT;
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_busy   <= 1'b1;
`ifdef CDAC_RX_TIMEOUT_EN
            r_idle   <= '0;
`endif
          end
        end
        SHIFT: begin
          // A bit arriving together with deselect is still part of the frame.
          if (w_sclk_rise) begin
            r_shreg <= {r_shreg[FRAME_BITS-2:0], w_sdata};
            if (r_bitcnt != 5'd31) r_bitcnt <= r_bitcnt + 5'd1;
          end
`ifdef CDAC_RX_TIMEOUT_EN
          if (w_sclk_rise) r_idle <= '0;
          else             r_idle <= r_idle + 8'd1;
`endif
          if (w_enb_rise) begin
            r_state <= CHECK;
            r_busy  <= 1'b0;
          end
`ifdef CDAC_RX_TIMEOUT_EN
          else if (!w_sclk_rise && r_idle == C_TO) begin
            r_state <= WAIT_HI;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
          end
`endif
        end
        CHECK: begin
          if (r_bitcnt == C_FULL) begin
            r_ctrl <= r_shreg[FRAME_BITS-1:CODE_W];
            r_code <= r_shreg[CODE_W-1:0];
            r_vld  <= 1'b1;
            r_cnt  <= r_cnt + 8'd1;
          end else begin
            r_err  <= 1'b1;
          end
          r_state <= IDLE;
        end
`ifdef CDAC_RX_TIMEOUT_EN
        WAIT_HI: begin
          if (w_lvl[2]) r_state <= IDLE;
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.CTRL      = r_ctrl;
  assign bus.CODE      = r_code;
  assign bus.DATA_VLD  = r_vld;
  assign bus.FRAME_ERR = r_err;
  assign bus.BUSY      = r_busy;
  assign bus.FRAME_CNT = r_cnt;

endmodule

// File: tb/tb_cdac_ser_rx.sv
// Directed self-checking bench for cdac_ser_rx: good, short/long, back-to-back,
// reset-mid-frame, same-cycle deselect and stalled frames (timeout with CDAC_RX_TIMEOUT_EN).
module tb_cdac_ser_rx;
  import cdac_rx_pkg::*;

  logic CLK40;
  logic RST_B;

  cdac_ser_rx_if bus ();

  cdac_ser_rx dut (
    .CLK40 (CLK40),
    .RST_B (RST_B),
    .bus   (bus)
  );

  initial CLK40 = 1'b0;
  always #5 CLK40 = ~CLK40;

  int checks   = 0;
  int errors   = 0;
  int vld_cyc  = 0;
  int err_cyc  = 0;
  int both_cyc = 0;

  // Strobe monitor: counts high cycles, so a stretched pulse shows up as an extra count.
  always @(negedge CLK40) begin
    if (bus.DATA_VLD === 1'b1) vld_cyc++;
    if (bus.FRAME_ERR === 1'b1) err_cyc++;
    if (bus.DATA_VLD === 1'b1 && bus.FRAME_ERR === 1'b1) both_cyc++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame();
    @(negedge CLK40);
    bus.DAC_ENB = 1'b0;
    repeat (4) @(negedge CLK40);
  endtask

  // 1 MHz SCLK: 20 CLK40 cycles low, 20 high; SDATA set well before the rise.
  task automatic send_bits(input logic [31:0] data, input int n);
    for (int b = n - 1; b >= 0; b--) begin
      bus.SDATA = data[b];
      repeat (20) @(negedge CLK40);
      bus.SCLK = 1'b1;
      repeat (20) @(negedge CLK40);
      bus.SCLK = 1'b0;
    end
  endtask

  task automatic wait_strobe(output int lat, output logic vld, output logic err);
    lat = -1;
    vld = 1'b0;
    err = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge CLK40);
      #1;
      if (bus.DATA_VLD === 1'b1 || bus.FRAME_ERR === 1'b1) begin
        lat = i;
        vld = bus.DATA_VLD;
        err = bus.FRAME_ERR;
        break;
      end
    end
    repeat (3) @(negedge CLK40);
  endtask

  task automatic end_frame(output int lat, output logic vld, output logic err);
    @(negedge CLK40);
    bus.DAC_ENB = 1'b1;
    wait_strobe(lat, vld, err);
  endtask

  initial begin
    int   lat;
    logic vld;
    logic err;
    int   v0;
    int   e0;

    RST_B       = 1'b0;
    bus.SCLK    = 1'b0;
    bus.SDATA   = 1'b0;
    bus.DAC_ENB = 1'b1;
    repeat (3) @(negedge CLK40);

    chk("rst_ctrl", 32'(bus.CTRL), 32'h0);
    chk("rst_code", 32'(bus.CODE), 32'h0);
    chk("rst_vld", 32'(bus.DATA_VLD), 32'h0);
    chk("rst_err", 32'(bus.FRAME_ERR), 32'h0);
    chk("rst_busy", 32'(bus.BUSY), 32'h0);
    chk("rst_cnt", 32'(bus.FRAME_CNT), 32'h0);

    RST_B = 1'b1;
    repeat (6) @(negedge CLK40);

    // Good frame 16'h8001
    v0 = vld_cyc; e0 = err_cyc;
    start_frame();
    send_bits(32'h8001, 16);
    end_frame(lat, vld, err);
    chk("good_lat", 32'(lat), 32'd4);
    chk("good_vld", 32'(vld), 32'h1);
    chk("good_ctrl", 32'(bus.CTRL), 32'h8);
    chk("good_code", 32'(bus.CODE), 32'h001);
    chk("good_cnt", 32'(bus.FRAME_CNT), 32'd1);
    chk("good_vld_cyc", 32'(vld_cyc - v0), 32'd1);
    chk("good_err_cyc", 32'(err_cyc - e0), 32'd0);

    // Short frame, 15 bits
    v0 = vld_cyc; e0 = err_cyc;
    start_frame();
    send_bits(32'h1234, 15);
    end_frame(lat, vld, err);
    chk("short_lat", 32'(lat), 32'd4);
    chk("short_err", 32'(err), 32'h1);
    chk("short_vld", 32'(vld), 32'h0);

    // Long frame, 17 bits; last 16 bits would read as FFFF if accepted
    start_frame();
    send_bits(32'h1FFFF, 17);
    end_frame(lat, vld, err);
    chk("long_err", 32'(err), 32'h1);
    chk("long_ctrl", 32'(bus.CTRL), 32'h8);
    chk("long_code", 32'(bus.CODE), 32'h001);
    chk("long_cnt", 32'(bus.FRAME_CNT), 32'd1);
    chk("bad_err_cyc", 32'(err_cyc - e0), 32'd2);
    chk("bad_vld_cyc", 32'(vld_cyc - v0), 32'd0);

    // Back-to-back frames, DAC_ENB high for 2 CLK40 cycles in between
    v0 = vld_cyc; e0 = err_cyc;
    start_frame();
    send_bits(32'h0FFF, 16);
    @(negedge CLK40);
    bus.DAC_ENB = 1'b1;
    repeat (2) @(negedge CLK40);
    bus.DAC_ENB = 1'b0;
    send_bits(32'h3A5C, 16);
    end_frame(lat, vld, err);
    chk("b2b_vld", 32'(vld), 32'h1);
    chk("b2b_ctrl", 32'(bus.CTRL), 32'h3);
    chk("b2b_code", 32'(bus.CODE), 32'hA5C);
    chk("b2b_cnt", 32'(bus.FRAME_CNT), 32'd3);
    chk("b2b_vld_cyc", 32'(vld_cyc - v0), 32'd2);
    chk("b2b_err_cyc", 32'(err_cyc - e0), 32'd0);

    // SCLK toggling while deselected
    v0 = vld_cyc; e0 = err_cyc;
    for (int i = 0; i < 20; i++) begin
      bus.SDATA = i[0];
      repeat (4) @(negedge CLK40);
      bus.SCLK = ~bus.SCLK;
    end
    bus.SCLK = 1'b0;
    repeat (10) @(negedge CLK40);
    chk("idle_busy", 32'(bus.BUSY), 32'h0);
    chk("idle_strobes", 32'(vld_cyc - v0 + err_cyc - e0), 32'd0);

    // Reset after 8 bits; DAC_ENB still low when reset is released
    start_frame();
    send_bits(32'hA5, 8);
    chk("mid_busy", 32'(bus.BUSY), 32'h1);
    @(negedge CLK40);
    RST_B = 1'b0;
    #1;
    chk("mrst_ctrl", 32'(bus.CTRL), 32'h0);
    chk("mrst_code", 32'(bus.CODE), 32'h0);
    chk("mrst_cnt", 32'(bus.FRAME_CNT), 32'h0);
    chk("mrst_busy", 32'(bus.BUSY), 32'h0);
    repeat (3) @(negedge CLK40);
    RST_B = 1'b1;
    repeat (10) @(negedge CLK40);
    send_bits(32'h5, 3);
    chk("noarm_busy", 32'(bus.BUSY), 32'h0);
    @(negedge CLK40);
    bus.DAC_ENB = 1'b1;
    repeat (10) @(negedge CLK40);
    chk("mrst_strobes", 32'(vld_cyc - v0 + err_cyc - e0), 32'd0);

    start_frame();
    send_bits(32'h1234, 16);
    end_frame(lat, vld, err);
    chk("post_vld", 32'(vld), 32'h1);
    chk("post_ctrl", 32'(bus.CTRL), 32'h1);
    chk("post_code", 32'(bus.CODE), 32'h234);
    chk("post_cnt", 32'(bus.FRAME_CNT), 32'd1);

    // Last SCLK rise and DAC_ENB rise in the same CLK40 cycle
    start_frame();
    send_bits(32'h7FFF, 15);
    bus.SDATA = 1'b1;
    repeat (20) @(negedge CLK40);
    bus.SCLK    = 1'b1;
    bus.DAC_ENB = 1'b1;
    wait_strobe(lat, vld, err);
    bus.SCLK = 1'b0;
    chk("same_lat", 32'(lat), 32'd4);
    chk("same_vld", 32'(vld), 32'h1);
    chk("same_ctrl", 32'(bus.CTRL), 32'hF);
    chk("same_code", 32'(bus.CODE), 32'hFFF);
    chk("same_cnt", 32'(bus.FRAME_CNT), 32'd2);

    // Stalled frame: 5 bits then SCLK stops
    v0 = vld_cyc; e0 = err_cyc;
    start_frame();
    send_bits(32'h15, 4);
    bus.SDATA = 1'b1;
    repeat (20) @(negedge CLK40);
    bus.SCLK = 1'b1;
`ifdef CDAC_RX_TIMEOUT_EN
    // 3 cycles to sync and register the edge, then TO_CYCLES+1 idle cycles.
    lat = -1;
    for (int i = 1; i <= 400; i++) begin
      @(posedge CLK40);
      #1;
      if (bus.FRAME_ERR === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk("to_lat", 32'(lat), 32'(DEF_TO_CYCLES + 4));
    repeat (3) @(negedge CLK40);
    chk("to_busy", 32'(bus.BUSY), 32'h0);
    bus.SCLK = 1'b0;
    @(negedge CLK40);
    bus.DAC_ENB = 1'b1;
    repeat (12) @(negedge CLK40);
    chk("to_err_cyc", 32'(err_cyc - e0), 32'd1);
    chk("to_vld_cyc", 32'(vld_cyc - v0), 32'd0);
`else
    repeat (20) @(negedge CLK40);
    bus.SCLK = 1'b0;
    repeat (400) @(negedge CLK40);
    chk("stall_busy", 32'(bus.BUSY), 32'h1);
    chk("stall_strobes", 32'(vld_cyc - v0 + err_cyc - e0), 32'd0);
    end_frame(lat, vld, err);
    chk("stall_lat", 32'(lat), 32'd4);
    chk("stall_err", 32'(err), 32'h1);
`endif
    chk("stall_cnt", 32'(bus.FRAME_CNT), 32'd2);
    chk("mutex", 32'(both_cyc), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
